complete_arb: RTL and testbench

COMPLETE_ARB -- requirements
Module: complete_arb

---
 rtl/complete_arb.sv | 192 +++++++++++++++++++
 tb/tb_complete_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/complete_arb.sv
// complete_arb -- functional-unit completion arbiter feeding the CDB.
//
// Each of NUM_CH completion channels owns a single holding entry
// (valid, dest, data, rob_index). A completion offered while the channel
// is ready is captured at the clock edge. From the next cycle it competes
// for one of CDB_WIDTH broadcast slots. Granted entries are broadcast
// combinationally from the holding registers. They are released at the
// end of the grant cycle, so a channel can refill back-to-back.
//
// Optional feature (macro COMPLETE_RR_EN):
//   defined   -> round-robin priority starting at rr_ptr
//   undefined -> fixed priority, channel 0 highest
//
// Ports:
//   clock, reset       sole clock; synchronous active-high reset
//   squash             flush every held completion, grant nothing
//   in_valid/in_ready  per-channel completion handshake
//   in_dest_idx        physical destination register per channel
//   in_result, in_npc  FU result / next PC per channel
//   in_take_branch     selects in_npc as the broadcast data
//   in_rob_index       ROB index per channel
//   cdb_valid/cdb_en   per-slot broadcast valid / register-write enable
//   cdb_idx/cdb_data/cdb_rob_index  per-slot broadcast payload
//   free_ch            per-channel pulse in the cycle its entry is granted

`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 5
`endif
`ifndef XLEN
`define XLEN 64
`endif
`ifndef ZERO_REG
`define ZERO_REG {(`PHYS_REG_IDX_SZ+1){1'b0}}
`endif

module complete_arb #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CDB_WIDTH = 2,
  parameter int unsigned ROB_IDX_W = 5
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      squash,
  input  logic [NUM_CH-1:0]                         in_valid,
  output logic [NUM_CH-1:0]                         in_ready,
  input  logic [NUM_CH-1:0][`PHYS_REG_IDX_SZ:0]     in_dest_idx,
  input  logic [NUM_CH-1:0][`XLEN-1:0]              in_result,
  input  logic [NUM_CH-1:0][`XLEN-1:0]              in_npc,
  input  logic [NUM_CH-1:0]                         in_take_branch,
  input  logic [NUM_CH-1:0][ROB_IDX_W-1:0]          in_rob_index,
  output logic [CDB_WIDTH-1:0]                      cdb_valid,
  output logic [CDB_WIDTH-1:0]                      cdb_en,
  output logic [CDB_WIDTH-1:0][`PHYS_REG_IDX_SZ:0]  cdb_idx,
  output logic [CDB_WIDTH-1:0][`XLEN-1:0]           cdb_data,
  output logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0]       cdb_rob_index,
  output logic [NUM_CH-1:0]                         free_ch
);

  localparam int unsigned IDX_W = `PHYS_REG_IDX_SZ + 1;

  logic [NUM_CH-1:0]                r_valid;
  logic [NUM_CH-1:0][IDX_W-1:0]     r_dest;
  logic [NUM_CH-1:0][`XLEN-1:0]     r_data;
  logic [NUM_CH-1:0][ROB_IDX_W-1:0] r_rob;

  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_capture;
  int unsigned       w_rank [NUM_CH];
  int unsigned       w_slot [NUM_CH];

`ifdef COMPLETE_RR_EN
  localparam int unsigned PTR_W = $clog2(NUM_CH);
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_rr_next;
  logic             w_any_grant;
`endif

  // Priority rank of each channel: 0 is most urgent. With round-robin
  // the ranking is rotated so that channel rr_ptr gets rank 0.
  always_comb begin
    int unsigned base;
    base = 0;
`ifdef COMPLETE_RR_EN
    base = 32'(r_rr_ptr);
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_rank[i] = (i >= base) ? (i - base) : (i + NUM_CH - base);
    end
  end

  // A valid entry is granted when fewer than CDB_WIDTH valid entries
  // outrank it; that count is also its slot number, which fills the
  // slots from 0 upward in priority order.
  always_comb begin
    int unsigned ahead;
    w_grant = '0;
    ahead   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ahead = 0;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (r_valid[j] && (w_rank[j] < w_rank[i])) begin
          ahead = ahead + 1;
        end
      end
      w_slot[i] = ahead;
      if (!reset && !squash && r_valid[i] && (ahead < CDB_WIDTH)) begin
        w_grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cdb_valid     = '0;
    cdb_en        = '0;
    cdb_idx       = '0;
    cdb_data      = '0;
    cdb_rob_index = '0;
    for (int unsigned s = 0; s < CDB_WIDTH; s++) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_grant[i] && (w_slot[i] == s)) begin
          cdb_valid[s]     = 1'b1;
          cdb_en[s]        = (r_dest[i] != `ZERO_REG);
          cdb_idx[s]       = r_dest[i];
          cdb_data[s]      = r_data[i];
          cdb_rob_index[s] = r_rob[i];
        end
      end
    end
  end

  always_comb begin
    if (reset) begin
      in_ready = '0;
    end else if (squash) begin
      in_ready = '1;
    end else begin
      in_ready = ~r_valid | w_grant;
    end
  end

  assign w_capture = (reset || squash) ? '0 : (in_valid & in_ready);
  assign free_ch   = w_grant;

  // A capture on a granted channel keeps the entry valid with new content.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
    end else if (squash) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_capture | (r_valid & ~w_grant);
    end
  end

  // Payload registers need no reset: they are only observed while valid.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_capture[i]) begin
        r_dest[i] <= in_dest_idx[i];
        r_data[i] <= in_take_branch[i] ? in_npc[i] : in_result[i];
        r_rob[i]  <= in_rob_index[i];
      end
    end
  end

`ifdef COMPLETE_RR_EN
  // The last granted channel is the granted one with the largest rank.
  always_comb begin
    int unsigned last_rank;
    int unsigned last_ch;
    w_any_grant = |w_grant;
    last_rank   = 0;
    last_ch     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_grant[i] && (w_rank[i] >= last_rank)) begin
        last_rank = w_rank[i];
        last_ch   = i;
      end
    end
    w_rr_next = ((last_ch + 1) >= NUM_CH) ? '0 : PTR_W'(last_ch + 1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_any_grant) begin
      r_rr_ptr <= w_rr_next;
    end
  end
`endif

endmodule

// File: tb/tb_complete_arb.sv
// tb_complete_arb -- directed self-checking bench for complete_arb
// (NUM_CH=4, CDB_WIDTH=2). Expectations adapt to COMPLETE_RR_EN.

`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 5
`endif
`ifndef XLEN
`define XLEN 64
`endif
`ifndef ZERO_REG
`define ZERO_REG {(`PHYS_REG_IDX_SZ+1){1'b0}}
`endif

module tb_complete_arb;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CDB_WIDTH = 2;
  localparam int unsigned ROB_IDX_W = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                                     reset;
  logic                                     squash;
  logic [NUM_CH-1:0]                        in_valid;
  logic [NUM_CH-1:0]                        in_ready;
  logic [NUM_CH-1:0][`PHYS_REG_IDX_SZ:0]    in_dest_idx;
  logic [NUM_CH-1:0][`XLEN-1:0]             in_result;
  logic [NUM_CH-1:0][`XLEN-1:0]             in_npc;
  logic [NUM_CH-1:0]                        in_take_branch;
  logic [NUM_CH-1:0][ROB_IDX_W-1:0]         in_rob_index;
  logic [CDB_WIDTH-1:0]                     cdb_valid;
  logic [CDB_WIDTH-1:0]                     cdb_en;
  logic [CDB_WIDTH-1:0][`PHYS_REG_IDX_SZ:0] cdb_idx;
  logic [CDB_WIDTH-1:0][`XLEN-1:0]          cdb_data;
  logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0]      cdb_rob_index;
  logic [NUM_CH-1:0]                        free_ch;

  int total = 0;
  int bad   = 0;

  complete_arb #(
    .NUM_CH   (NUM_CH),
    .CDB_WIDTH(CDB_WIDTH),
    .ROB_IDX_W(ROB_IDX_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dest_idx   (in_dest_idx),
    .in_result     (in_result),
    .in_npc        (in_npc),
    .in_take_branch(in_take_branch),
    .in_rob_index  (in_rob_index),
    .cdb_valid     (cdb_valid),
    .cdb_en        (cdb_en),
    .cdb_idx       (cdb_idx),
    .cdb_data      (cdb_data),
    .cdb_rob_index (cdb_rob_index),
    .free_ch       (free_ch)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [1:0] v, input logic [1:0] en,
                         input logic [3:0] fr, input logic [3:0] rdy);
    chk({tag, ".cdb_valid"}, 64'(cdb_valid), 64'(v));
    chk({tag, ".cdb_en"},    64'(cdb_en),    64'(en));
    chk({tag, ".free_ch"},   64'(free_ch),   64'(fr));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [5:0] dest, input logic [63:0] res,
                        input logic [63:0] npc, input logic tb, input logic [4:0] rob);
    in_valid[ch]       = 1'b1;
    in_dest_idx[ch]    = dest;
    in_result[ch]      = res;
    in_npc[ch]         = npc;
    in_take_branch[ch] = tb;
    in_rob_index[ch]   = rob;
  endtask

  task automatic idle;
    in_valid       = '0;
    in_take_branch = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; squash = 1'b0;
    in_valid = '0; in_dest_idx = '0; in_result = '0; in_npc = '0;
    in_take_branch = '0; in_rob_index = '0;

    // Reset for two cycles while every channel offers a completion.
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 6'(c + 1), 64'hAA, 64'h0, 1'b0, 5'(c));
    tick;
    tick;
    chk_ctl("rst", 2'b00, 2'b00, 4'b0000, 4'b0000);
    reset = 1'b0;
    idle;
    #1;
    chk_ctl("rel", 2'b00, 2'b00, 4'b0000, 4'b1111);

    // Single completion on ch1, broadcast one cycle later.
    set_ch(1, 6'd7, 64'h55, 64'h999, 1'b0, 5'd3);
    tick;
    idle;
    #1;
    chk_ctl("ch1", 2'b01, 2'b01, 4'b0010, 4'b1111);
    chk("ch1.idx",  64'(cdb_idx[0]),       64'd7);
    chk("ch1.data", cdb_data[0],           64'h55);
    chk("ch1.rob",  64'(cdb_rob_index[0]), 64'd3);
    tick;
    chk_ctl("ch1.after", 2'b00, 2'b00, 4'b0000, 4'b1111);

    // Taken branch to the zero register: data is NPC, no write enable.
    set_ch(2, 6'd0, 64'hDEAD, 64'h104, 1'b1, 5'd9);
    tick;
    idle;
    #1;
    chk_ctl("br", 2'b01, 2'b00, 4'b0100, 4'b1111);
    chk("br.data", cdb_data[0],           64'h104);
    chk("br.rob",  64'(cdb_rob_index[0]), 64'd9);
    tick;

    // Re-reset so both priority schemes start from channel 0.
    reset = 1'b1;
    tick;
    reset = 1'b0;

    // All four channels at once: {0,1} first, then {2,3}.
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 6'(c + 8), 64'(32'h100 + c), 64'h0, 1'b0, 5'(c + 20));
    tick;
    idle;
    #1;
    chk_ctl("all.c1", 2'b11, 2'b11, 4'b0011, 4'b0011);
    chk("all.c1.idx0",  64'(cdb_idx[0]), 64'd8);
    chk("all.c1.idx1",  64'(cdb_idx[1]), 64'd9);
    chk("all.c1.data1", cdb_data[1],     64'h101);
    tick;
    chk_ctl("all.c2", 2'b11, 2'b11, 4'b1100, 4'b1111);
    chk("all.c2.idx0", 64'(cdb_idx[0]),       64'd10);
    chk("all.c2.idx1", 64'(cdb_idx[1]),       64'd11);
    chk("all.c2.rob1", 64'(cdb_rob_index[1]), 64'd23);
    tick;
    chk_ctl("all.c3", 2'b00, 2'b00, 4'b0000, 4'b1111);

    // Squash with three entries held; an offer during squash is dropped.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) set_ch(c, 6'(c + 1), 64'(c), 64'h0, 1'b0, 5'(c));
    tick;
    idle;
    squash = 1'b1;
    set_ch(3, 6'd5, 64'h77, 64'h0, 1'b0, 5'd1);
    #1;
    chk_ctl("sq", 2'b00, 2'b00, 4'b0000, 4'b1111);
    tick;
    squash = 1'b0;
    idle;
    #1;
    chk_ctl("sq.after", 2'b00, 2'b00, 4'b0000, 4'b1111);
    tick;
    chk_ctl("sq.after2", 2'b00, 2'b00, 4'b0000, 4'b1111);

    // Reset while two entries are held.
    set_ch(1, 6'd12, 64'h1, 64'h0, 1'b0, 5'd1);
    set_ch(3, 6'd13, 64'h3, 64'h0, 1'b0, 5'd3);
    tick;
    idle;
    reset = 1'b1;
    #1;
    chk_ctl("rst2", 2'b00, 2'b00, 4'b0000, 4'b0000);
    tick;
    reset = 1'b0;
    #1;
    chk_ctl("rst2.rel", 2'b00, 2'b00, 4'b0000, 4'b1111);
    tick;
    chk_ctl("rst2.rel2", 2'b00, 2'b00, 4'b0000, 4'b1111);

    // All channels refill every cycle.
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 6'(c + 1), 64'(32'h300 + c), 64'h0, 1'b0, 5'(c));
    tick;
    for (int k = 1; k <= 4; k++) begin
`ifdef COMPLETE_RR_EN
      if (k % 2 == 1) begin
        chk_ctl($sformatf("fill.c%0d", k), 2'b11, 2'b11, 4'b0011, 4'b0011);
        chk($sformatf("fill.c%0d.idx0", k), 64'(cdb_idx[0]), 64'd1);
        chk($sformatf("fill.c%0d.idx1", k), 64'(cdb_idx[1]), 64'd2);
      end else begin
        chk_ctl($sformatf("fill.c%0d", k), 2'b11, 2'b11, 4'b1100, 4'b1100);
        chk($sformatf("fill.c%0d.idx0", k), 64'(cdb_idx[0]), 64'd3);
        chk($sformatf("fill.c%0d.idx1", k), 64'(cdb_idx[1]), 64'd4);
      end
`else
      chk_ctl($sformatf("fill.c%0d", k), 2'b11, 2'b11, 4'b0011, 4'b0011);
      chk($sformatf("fill.c%0d.idx0", k), 64'(cdb_idx[0]), 64'd1);
      chk($sformatf("fill.c%0d.idx1", k), 64'(cdb_idx[1]), 64'd2);
`endif
      tick;
    end
    idle;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
